// File: rtl/timer_share_arb_if.sv
// Bundle between timer_share_arb, its requesters and the shared countdown timer.
// The arbiter connects through the slave modport; the surrounding logic drives the master side.
interface timer_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_val;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       expire;
  logic                     busy;
  logic [OW-1:0]            owner;
  logic                     wdog_err;
  logic                     tmr_start;
  logic [CNT_W-1:0]         tmr_load_val;
  logic                     tmr_done;

  modport slave (
    input  req, req_val, tmr_done,
    output gnt, expire, busy, owner, wdog_err, tmr_start, tmr_load_val
  );

  modport master (
    output req, req_val, tmr_done,
    input  gnt, expire, busy, owner, wdog_err, tmr_start, tmr_load_val
  );
endinterface

// File: rtl/timer_share_arb.sv
// Round-robin sharing of one countdown timer between NUM_REQ requesters,
// with a watchdog that gives up on a timer that never reports done.
//
// state | meaning
// IDLE  | no timeout running; arbitrate pending requests
// LOAD  | one cycle: pulse tmr_start and gnt to the new owner
// WAIT  | timer running; wait for tmr_done or watchdog expiry
module timer_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = 4,
  parameter int WDOG_CYCLES = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  timer_share_arb_if.slave   bus
);
  localparam int OW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = $clog2(WDOG_CYCLES);
  localparam logic [OW:0]     NUM_REQ_X = (OW+1)'(NUM_REQ);
  localparam logic [OW-1:0]   LAST_IDX  = OW'(NUM_REQ - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] expire_q, expire_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic               found;
  logic [OW-1:0]      sel;
  logic [OW:0]        cand;
  logic [OW-1:0]      nxt_ptr;
  logic [CNT_W-1:0]   vals [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      vals[i] = bus.req_val[i*CNT_W +: CNT_W];
    end
  end

  // First pending request at or after rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (OW+1)'(k);
      if (cand >= NUM_REQ_X) cand = cand - NUM_REQ_X;
      if (!found && bus.req[cand[OW-1:0]]) begin
        found = 1'b1;
        sel   = cand[OW-1:0];
      end
    end
  end

  assign nxt_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    load_d   = load_q;
    gnt_d    = '0;
    expire_d = '0;
    start_d  = 1'b0;
    err_d    = err_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = LOAD;
          owner_d    = sel;
          load_d     = vals[sel];
          gnt_d[sel] = 1'b1;
          start_d    = 1'b1;
        end
      end
      LOAD: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.tmr_done) begin
          expire_d[owner_q] = 1'b1;
          ptr_d             = nxt_ptr;
          state_d           = IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      load_q   <= '0;
      gnt_q    <= '0;
      expire_q <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      load_q   <= load_d;
      gnt_q    <= gnt_d;
      expire_q <= expire_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.expire       = expire_q;
  assign bus.busy         = busy_q;
  assign bus.owner        = owner_q;
  assign bus.wdog_err     = err_q;
  assign bus.tmr_start    = start_q;
  assign bus.tmr_load_val = load_q;
endmodule

// File: tb/tb_timer_share_arb.sv
// Directed bench for timer_share_arb with a behavioural model of the shared countdown timer.
module tb_timer_share_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   viol = 0;

  always #5 clk = ~clk;

  timer_share_arb_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

  timer_share_arb #(.NUM_REQ(4), .CNT_W(4), .WDOG_CYCLES(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Timer model: start in cycle L with value N gives done in cycle L+N+1.
  logic       never_done = 1'b0;
  logic       stray_done = 1'b0;
  logic       t_done, t_run;
  logic [3:0] t_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_done <= 1'b0;
      t_run  <= 1'b0;
      t_cnt  <= 4'd0;
    end else begin
      t_done <= 1'b0;
      if (bus.tmr_start) begin
        if (bus.tmr_load_val == 4'd0) t_done <= 1'b1;
        else begin
          t_cnt <= bus.tmr_load_val - 4'd1;
          t_run <= 1'b1;
        end
      end else if (t_run) begin
        if (t_cnt == 4'd0) begin
          t_done <= 1'b1;
          t_run  <= 1'b0;
        end else t_cnt <= t_cnt - 4'd1;
      end
    end
  end

  assign bus.tmr_done = (t_done & ~never_done) | stray_done;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(bus.gnt) > 1 || $countones(bus.expire) > 1 ||
          (bus.gnt & bus.expire) != 4'd0 || (bus.tmr_start && bus.tmr_done))
        viol <= viol + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_val = '0;
    never_done = 1'b0;
    stray_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int exp_seen, busy_seen;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_val = '0;
    repeat (2) tick();
    total_cnt++;
    if ({bus.gnt, bus.expire, bus.busy, bus.owner, bus.wdog_err, bus.tmr_start, bus.tmr_load_val} !== 17'd0)
      $display("FAIL reset_outputs got gnt=%b exp=%b busy=%b own=%0d err=%b st=%b ld=%0d want all 0",
               bus.gnt, bus.expire, bus.busy, bus.owner, bus.wdog_err, bus.tmr_start, bus.tmr_load_val);
    else pass_cnt++;
    rst_n = 1'b1;
    bus.req = 4'b0100;
    bus.req_val = 16'h0900;
    tick();
    total_cnt++;
    if (bus.tmr_load_val !== 4'd9) $display("FAIL reset_pre_load got %0d want 9", bus.tmr_load_val);
    else pass_cnt++;
    bus.req = '0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.gnt, bus.expire, bus.busy, bus.owner, bus.wdog_err, bus.tmr_start, bus.tmr_load_val} !== 17'd0)
      $display("FAIL reset_async got busy=%b own=%0d ld=%0d want all 0", bus.busy, bus.owner, bus.tmr_load_val);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.expire != 4'd0) exp_seen++;
      if (bus.busy) busy_seen++;
    end
    total_cnt++;
    if (exp_seen !== 0) $display("FAIL reset_no_expire got %0d pulses want 0", exp_seen);
    else pass_cnt++;
    total_cnt++;
    if (busy_seen !== 0) $display("FAIL reset_idle got %0d busy cycles want 0", busy_seen);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    bus.req = 4'b0100;
    bus.req_val = 16'h0500;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0100) $display("FAIL single_gnt got %b want 0100", bus.gnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.tmr_start !== 1'b1 || bus.tmr_load_val !== 4'd5)
      $display("FAIL single_start got st=%b ld=%0d want st=1 ld=5", bus.tmr_start, bus.tmr_load_val);
    else pass_cnt++;
    total_cnt++;
    if (bus.owner !== 2'd2 || bus.busy !== 1'b1)
      $display("FAIL single_owner got own=%0d busy=%b want own=2 busy=1", bus.owner, bus.busy);
    else pass_cnt++;
    bus.req = '0;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.expire != 4'd0) begin
        n = i;
        break;
      end
    end
    total_cnt++;
    if (n !== 7) $display("FAIL single_latency got %0d want 7", n);
    else pass_cnt++;
    total_cnt++;
    if (bus.expire !== 4'b0100 || bus.busy !== 1'b0)
      $display("FAIL single_expire got exp=%b busy=%b want exp=0100 busy=0", bus.expire, bus.busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.expire !== 4'b0000) $display("FAIL single_pulse got %b want 0000", bus.expire);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int order[$];
    int times[$];
    int loads[$];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int exp_l[5] = '{3, 1, 0, 2, 3};
    int exp_gap[4] = '{6, 4, 3, 5};
    int idx;
    do_reset();
    bus.req = 4'b1111;
    bus.req_val = 16'h2013;
    for (int i = 0; i < 80 && order.size() < 5; i++) begin
      tick();
      if (bus.gnt != 4'd0) begin
        idx = 0;
        for (int b = 3; b >= 0; b--) if (bus.gnt[b]) idx = b;
        order.push_back(idx);
        times.push_back(i);
        loads.push_back(int'(bus.tmr_load_val));
        bus.req[idx] = 1'b0;
        if (order.size() == 4) bus.req[0] = 1'b1;
      end
    end
    bus.req = '0;
    total_cnt++;
    if (order.size() !== 5) $display("FAIL rr_count got %0d grants want 5", order.size());
    else pass_cnt++;
    while (order.size() < 5) begin
      order.push_back(-1);
      times.push_back(-1000);
      loads.push_back(-1);
    end
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (order[k] !== exp_o[k] || loads[k] !== exp_l[k])
        $display("FAIL rr_grant%0d got req=%0d ld=%0d want req=%0d ld=%0d", k, order[k], loads[k], exp_o[k], exp_l[k]);
      else pass_cnt++;
    end
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (times[k+1] - times[k] !== exp_gap[k])
        $display("FAIL rr_back_to_back%0d got gap %0d want %0d", k, times[k+1] - times[k], exp_gap[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_load();
    do_reset();
    bus.req = 4'b0010;
    bus.req_val = 16'h0000;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0010 || bus.tmr_start !== 1'b1 || bus.tmr_done !== 1'b0)
      $display("FAIL zero_load got gnt=%b st=%b done=%b want 0010/1/0", bus.gnt, bus.tmr_start, bus.tmr_done);
    else pass_cnt++;
    bus.req = '0;
    tick();
    total_cnt++;
    if (bus.tmr_done !== 1'b1 || bus.tmr_start !== 1'b0)
      $display("FAIL zero_done got done=%b st=%b want 1/0", bus.tmr_done, bus.tmr_start);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.expire !== 4'b0010) $display("FAIL zero_expire got %b want 0010", bus.expire);
    else pass_cnt++;
  endtask

  task automatic test_watchdog();
    int n, exp_seen, gnt_seen;
    do_reset();
    never_done = 1'b1;
    bus.req = 4'b0001;
    bus.req_val = 16'h000F;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0001) $display("FAIL wdog_gnt0 got %b want 0001", bus.gnt);
    else pass_cnt++;
    bus.req = 4'b0010;
    bus.req_val = 16'h002F;
    n = -1;
    exp_seen = 0;
    gnt_seen = 0;
    // LOAD cycle, 24 WAIT cycles, then the error is visible.
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.expire != 4'd0) exp_seen++;
      if (bus.gnt != 4'd0) gnt_seen++;
      if (bus.wdog_err) begin
        n = i;
        break;
      end
    end
    total_cnt++;
    if (n !== 25) $display("FAIL wdog_time got %0d want 25", n);
    else pass_cnt++;
    total_cnt++;
    if (exp_seen !== 0 || gnt_seen !== 0)
      $display("FAIL wdog_quiet got expire=%0d gnt=%0d want 0/0", exp_seen, gnt_seen);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL wdog_idle got busy=%b want 0", bus.busy);
    else pass_cnt++;
    never_done = 1'b0;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0010 || bus.tmr_load_val !== 4'd2)
      $display("FAIL wdog_next got gnt=%b ld=%0d want 0010/2", bus.gnt, bus.tmr_load_val);
    else pass_cnt++;
    bus.req = '0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.expire != 4'd0) begin
        n = i;
        break;
      end
    end
    total_cnt++;
    if (n !== 4 || bus.expire !== 4'b0010 || bus.wdog_err !== 1'b1)
      $display("FAIL wdog_sticky got n=%0d exp=%b err=%b want 4/0010/1", n, bus.expire, bus.wdog_err);
    else pass_cnt++;
  endtask

  task automatic test_ignored();
    int n, gnt_seen, bad;
    do_reset();
    bus.req = 4'b0001;
    bus.req_val = 16'h0006;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0001) $display("FAIL ign_gnt0 got %b want 0001", bus.gnt);
    else pass_cnt++;
    bus.req = 4'b1000;
    bus.req_val = 16'h1006;
    n = -1;
    gnt_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.gnt != 4'd0) gnt_seen++;
      if (bus.expire != 4'd0) begin
        n = i;
        break;
      end
    end
    total_cnt++;
    if (n !== 8 || bus.expire !== 4'b0001 || gnt_seen !== 0)
      $display("FAIL ign_wait got n=%0d exp=%b gnts=%0d want 8/0001/0", n, bus.expire, gnt_seen);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3)
      $display("FAIL ign_gnt3 got gnt=%b own=%0d want 1000/3", bus.gnt, bus.owner);
    else pass_cnt++;
    bus.req = '0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.expire != 4'd0) begin
        n = i;
        break;
      end
    end
    total_cnt++;
    if (n !== 3 || bus.expire !== 4'b1000)
      $display("FAIL ign_expire3 got n=%0d exp=%b want 3/1000", n, bus.expire);
    else pass_cnt++;
    stray_done = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy || bus.tmr_start || bus.expire != 4'd0 || bus.gnt != 4'd0) bad++;
    end
    stray_done = 1'b0;
    total_cnt++;
    if (bad !== 0) $display("FAIL ign_stray_done got %0d glitch cycles want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_invariants();
    total_cnt++;
    if (viol !== 0) $display("FAIL invariants got %0d violating cycles want 0", viol);
    else pass_cnt++;
  endtask

  initial begin
    bus.req = '0;
    bus.req_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_load();
    test_watchdog();
    test_ignored();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
